// File: rtl/fir_mac_param.sv
// Signed time-multiplexed FIR filter with a single multiply-accumulate unit.
// It has run-time loadable coefficients, round-half-up saturating output and a bypass path.
module fir_mac_param #(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int TAPS      = 8,
   parameter int OUT_SHIFT = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      bypass,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic [COEF_W-1:0]         coef_data,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic                      sat_flag,
   output logic                      busy
);

   localparam int AW     = $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + AW;

   localparam logic [AW:0]           TAPS_N  = (AW+1)'(TAPS);
   localparam logic [AW-1:0]         LAST    = AW'(TAPS - 1);
   localparam logic [ACC_W:0]        HALF    = (ACC_W+1)'(1) << (OUT_SHIFT - 1);
   localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;
   localparam logic [COEF_W-1:0]     UNITY   = COEF_W'(1) << OUT_SHIFT;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;
   localparam logic [1:0] S_BYP  = 2'd3;

   logic [1:0]               state;
   logic [DATA_W-1:0]        line [TAPS];
   logic [COEF_W-1:0]        coef [TAPS];
   logic [AW-1:0]            wptr;
   logic [AW-1:0]            k;
   logic [AW-1:0]            rd_idx;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W:0]    rounded;
   logic [DATA_W-1:0]        result;
   logic                     clip;

   assign in_ready = (state == S_IDLE);
   assign busy     = (state != S_IDLE);

   // x[k] lives at (wptr - k) mod TAPS; handle wrap explicitly for non power-of-two lengths
   always_comb begin
      if (k <= wptr)
         rd_idx = wptr - k;
      else
         rd_idx = AW'({1'b0, wptr} + TAPS_N - {1'b0, k});
   end

   assign prod    = PROD_W'($signed(line[rd_idx])) * PROD_W'($signed(coef[k]));
   assign rounded = ($signed({acc[ACC_W-1], acc}) + $signed(HALF)) >>> OUT_SHIFT;

   always_comb begin
      clip   = 1'b0;
      result = rounded[DATA_W-1:0];
      if (rounded > SAT_MAX) begin
         clip   = 1'b1;
         result = SAT_MAX[DATA_W-1:0];
      end else if (rounded < SAT_MIN) begin
         clip   = 1'b1;
         result = SAT_MIN[DATA_W-1:0];
      end
   end

   // Bypass preloads the accumulator with the scaled sample so OUT reproduces it exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
         wptr      <= '0;
         k         <= '0;
         acc       <= '0;
         for (int i = 0; i < TAPS; i++) begin
            line[i] <= '0;
            coef[i] <= (i == 0) ? UNITY : '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (state == S_IDLE && coef_we && ({1'b0, coef_addr} < TAPS_N))
            coef[coef_addr] <= coef_data;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  line[wptr] <= in_data;
                  k          <= '0;
                  if (bypass) begin
                     acc   <= {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data} <<< OUT_SHIFT;
                     state <= S_BYP;
                  end else begin
                     acc   <= '0;
                     state <= S_MAC;
                  end
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               k   <= (k == LAST) ? '0 : k + 1'b1;
               if (k == LAST)
                  state <= S_OUT;
            end
            S_BYP: state <= S_OUT;
            S_OUT: begin
               out_data  <= result;
               sat_flag  <= clip;
               out_valid <= 1'b1;
               wptr      <= (wptr == LAST) ? '0 : wptr + 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_param.sv
// Directed bench for fir_mac_param: an eight-tap instance plus a five-tap instance that shares its inputs.
// The five-tap instance covers the non power-of-two length and the out-of-range coefficient address.
module tb_fir_mac_param;

   logic       clk = 1'b0;
   logic       rst, in_valid, bypass, coef_we;
   logic [7:0] in_data, coef_data;
   logic [2:0] coef_addr;
   logic       in_ready, out_valid, sat_flag, busy;
   logic [7:0] out_data;
   logic       b_in_ready, b_out_valid, b_sat_flag, b_busy;
   logic [7:0] b_out_data;
   int         passed = 0;
   int         total  = 0;

   always #5 clk = ~clk;

   fir_mac_param #(.DATA_W(8), .COEF_W(8), .TAPS(8), .OUT_SHIFT(6)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_data(out_data), .sat_flag(sat_flag), .busy(busy));

   fir_mac_param #(.DATA_W(8), .COEF_W(8), .TAPS(5), .OUT_SHIFT(6)) dut5 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
      .bypass(bypass), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(b_out_valid), .out_data(b_out_data), .sat_flag(b_sat_flag), .busy(b_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = d;
      tick();
      coef_we = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (out_valid) break;
      end
   endtask

   // Sends one sample and measures edges to out_valid, in_ready-low cycles and pulse width
   task automatic send(input logic [7:0] x, input logic byp, output logic [7:0] y,
                       output logic sf, output int lat, output int lowc, output logic pulse_ok);
      in_valid = 1'b1;
      in_data  = x;
      bypass   = byp;
      tick();
      in_valid = 1'b0;
      bypass   = 1'b0;
      lat  = 0;
      lowc = 0;
      if (!in_ready) lowc++;
      while (lat < 40) begin
         tick();
         lat++;
         if (out_valid) break;
         if (!in_ready) lowc++;
      end
      y  = out_data;
      sf = sat_flag;
      tick();
      pulse_ok = !out_valid;
   endtask

   task automatic test_reset();
      total++;
      if (out_valid !== 1'b0 || out_data !== 8'd0 || sat_flag !== 1'b0) begin
         $display("[TB] FAIL reset_outputs: got v=%b d=%0d s=%b want 0 0 0", out_valid, out_data, sat_flag);
      end else passed++;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         $display("[TB] FAIL reset_idle: got ready=%b busy=%b want 1 0", in_ready, busy);
      end else passed++;
   endtask

   task automatic test_identity();
      int vin [3] = '{10, -20, 127};
      logic [7:0] y;
      logic sf, pok;
      int lat, lowc;
      for (int i = 0; i < 3; i++) begin
         send(8'(vin[i]), 1'b0, y, sf, lat, lowc, pok);
         total++;
         if (y !== 8'(vin[i])) begin
            $display("[TB] FAIL identity_data[%0d]: got %0d want %0d", i, $signed(y), vin[i]);
         end else passed++;
         total++;
         if (lat != 9 || lowc != 9 || pok !== 1'b1 || sf !== 1'b0) begin
            $display("[TB] FAIL identity_timing[%0d]: got lat=%0d low=%0d single=%b sat=%b want 9 9 1 0",
                     i, lat, lowc, pok, sf);
         end else passed++;
      end
   endtask

   task automatic test_moving_avg();
      logic [7:0] y, want;
      logic sf, pok;
      int lat, lowc;
      do_reset();
      for (int i = 0; i < 8; i++) write_coef(3'(i), 8'd8);
      for (int i = 0; i < 9; i++) begin
         send((i == 0) ? 8'd64 : 8'd0, 1'b0, y, sf, lat, lowc, pok);
         want = (i < 8) ? 8'd8 : 8'd0;
         total++;
         if (y !== want) begin
            $display("[TB] FAIL avg_impulse[%0d]: got %0d want %0d", i, $signed(y), want);
         end else passed++;
      end
      for (int i = 0; i < 8; i++) begin
         send(8'd100, 1'b0, y, sf, lat, lowc, pok);
         if (i == 0) begin
            total++;
            if (y !== 8'd13) $display("[TB] FAIL avg_step_first: got %0d want 13", $signed(y));
            else passed++;
         end
      end
      total++;
      if (y !== 8'd100) $display("[TB] FAIL avg_step_settled: got %0d want 100", $signed(y));
      else passed++;
   endtask

   task automatic test_saturation();
      logic [7:0] vin [4] = '{8'd100, 8'h9C, 8'd3, 8'hFD};
      logic [7:0] want [4] = '{8'd127, 8'h80, 8'd2, 8'hFF};
      logic       wsat [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [7:0] y;
      logic sf, pok;
      int lat, lowc;
      do_reset();
      write_coef(3'd0, 8'd127);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) write_coef(3'd0, 8'd32);
         send(vin[i], 1'b0, y, sf, lat, lowc, pok);
         total++;
         if (y !== want[i] || sf !== wsat[i]) begin
            $display("[TB] FAIL sat_round[%0d]: got %0d sat=%b want %0d sat=%b",
                     i, $signed(y), sf, $signed(want[i]), wsat[i]);
         end else passed++;
      end
   endtask

   task automatic test_bypass();
      logic [7:0] y;
      logic sf, pok;
      int lat, lowc;
      do_reset();
      send(8'd55, 1'b1, y, sf, lat, lowc, pok);
      total++;
      if (y !== 8'd55 || sf !== 1'b0 || lat != 2 || pok !== 1'b1) begin
         $display("[TB] FAIL bypass_pass: got %0d sat=%b lat=%0d single=%b want 55 0 2 1",
                  $signed(y), sf, lat, pok);
      end else passed++;
      write_coef(3'd0, 8'd0);
      write_coef(3'd1, 8'd64);
      send(8'd0, 1'b0, y, sf, lat, lowc, pok);
      total++;
      if (y !== 8'd55) $display("[TB] FAIL bypass_history: got %0d want 55", $signed(y));
      else passed++;
   endtask

   task automatic test_coef_busy();
      logic [7:0] y;
      logic sf, pok;
      int lat, lowc, n;
      do_reset();
      in_valid = 1'b1;
      in_data  = 8'd20;
      tick();
      in_valid  = 1'b0;
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'd0;
      tick();
      tick();
      tick();
      coef_we = 1'b0;
      wait_out(n);
      total++;
      if (out_data !== 8'd20 || n != 6) begin
         $display("[TB] FAIL busy_write_sample: got %0d after %0d want 20 after 6", $signed(out_data), n);
      end else passed++;
      tick();
      send(8'd33, 1'b0, y, sf, lat, lowc, pok);
      total++;
      if (y !== 8'd33) $display("[TB] FAIL busy_write_ignored: got %0d want 33", $signed(y));
      else passed++;
      in_valid  = 1'b1;
      in_data   = 8'd40;
      coef_we   = 1'b1;
      coef_addr = 3'd0;
      coef_data = 8'd32;
      tick();
      in_valid = 1'b0;
      coef_we  = 1'b0;
      wait_out(n);
      total++;
      if (out_data !== 8'd20) $display("[TB] FAIL same_cycle_write: got %0d want 20", $signed(out_data));
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid_mac();
      logic [7:0] y;
      logic sf, pok;
      int lat, lowc, pulses;
      do_reset();
      send(8'd1, 1'b0, y, sf, lat, lowc, pok);
      in_valid = 1'b1;
      in_data  = 8'd50;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         $display("[TB] FAIL midmac_idle: got ready=%b busy=%b want 1 0", in_ready, busy);
      end else passed++;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid) pulses++;
         tick();
      end
      total++;
      if (pulses != 0) $display("[TB] FAIL midmac_no_output: got %0d pulses want 0", pulses);
      else passed++;
      for (int i = 1; i < 8; i++) write_coef(3'(i), 8'd64);
      send(8'd42, 1'b0, y, sf, lat, lowc, pok);
      total++;
      if (y !== 8'd42 || lat != 9) begin
         $display("[TB] FAIL midmac_cleared: got %0d lat=%0d want 42 lat=9", $signed(y), lat);
      end else passed++;
   endtask

   task automatic test_five_taps();
      int n, m;
      do_reset();
      write_coef(3'd5, 8'd0);
      write_coef(3'd7, 8'd0);
      in_valid = 1'b1;
      in_data  = 8'd9;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (n < 40) begin
         tick();
         n++;
         if (b_out_valid) break;
      end
      total++;
      if (b_out_data !== 8'd9 || n != 6 || b_sat_flag !== 1'b0) begin
         $display("[TB] FAIL five_tap_identity: got %0d lat=%0d sat=%b want 9 lat=6 sat=0",
                  $signed(b_out_data), n, b_sat_flag);
      end else passed++;
      wait_out(m);
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'd0;
      bypass    = 1'b0;
      coef_we   = 1'b0;
      coef_addr = 3'd0;
      coef_data = 8'd0;
      do_reset();
      test_reset();
      test_identity();
      test_moving_avg();
      test_saturation();
      test_bypass();
      test_coef_busy();
      test_reset_mid_mac();
      test_five_taps();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fir_mac_param.md
Name: fir_mac_param

Overview:
- Parametrised successor to the fixed 8-bit FIR: a signed, time-multiplexed single-MAC FIR filter.
- Configurable data width, coefficient width and tap count, with run-time-loadable coefficients.
- Valid/ready input handshake, rounding plus saturating output, and a bypass mode.
- Sits between the pad-level input sample bus and the output bus; strobes are exported for debug pins.

Parameters:
DATA_W, 8, signed sample width (input and output)
COEF_W, 8, signed coefficient width
TAPS, 8, filter length, >=2
OUT_SHIFT, 6, coefficient fraction bits (1.0 = 1<<OUT_SHIFT); constraint 1 <= OUT_SHIFT <= COEF_W-2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  block can accept a sample (high only in IDLE)
in_data  in  DATA_W  signed input sample
bypass  in  1  sampled at acceptance; 1 = pass the sample through unfiltered
coef_we  in  1  coefficient write strobe
coef_addr  in  clog2(TAPS)  coefficient index
coef_data  in  COEF_W  signed coefficient value
out_valid  out  1  one-cycle pulse, out_data is new
out_data  out  DATA_W  signed filtered sample, held between pulses
sat_flag  out  1  last output was clipped; updated with out_valid
busy  out  1  high in MAC or OUT state

Behaviour:
- Reset (rst=1 at an edge), synchronous only, takes effect regardless of state:
  - state IDLE; out_valid=0, out_data=0, sat_flag=0.
  - Delay line all zero; write pointer wptr=0.
  - Coefficients set to identity: c[0]=1<<OUT_SHIFT, all others 0.
  - Reset mid-MAC aborts the computation; no out_valid is produced.
- Storage: circular delay line of TAPS samples. x[k] = sample accepted k samples ago = line[(wptr-k) mod TAPS].
- FSM IDLE -> MAC -> OUT -> IDLE:
  - IDLE: in_ready=1. On an edge with in_valid=1:
    - write in_data to line[wptr];
    - if bypass=0: clear acc, set k=0, go to MAC;
    - if bypass=1: go to BYP.
  - MAC: each edge performs acc += x[k]*c[k] and increments k. After k=TAPS-1, go to OUT. Exactly TAPS cycles.
  - OUT: one edge forms r = (acc + (1<<(OUT_SHIFT-1))) >>> OUT_SHIFT (round half up), then saturates r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - Registers out_data and sat_flag; out_valid=1 for that one cycle.
    - wptr = (wptr+1) mod TAPS; go to IDLE.
  - BYP (busy=1, one cycle): out_data = accepted sample, sat_flag=0, out_valid pulse, wptr advances, go to IDLE.
- Latency: with acceptance at edge E0, out_valid is high in the cycle following edge E0+TAPS+1 (bypass: following edge E0+2).
- Filtered throughput: one sample per TAPS+2 cycles.
- in_ready and out_valid may be high in the same cycle.
- Widths:
  - product is DATA_W+COEF_W signed;
  - accumulator is DATA_W+COEF_W+clog2(TAPS) signed and never overflows;
  - all arithmetic is two's complement.
- Bypass samples enter the delay line, so filter history stays continuous across a mode change.
- Coefficient writes:
  - applied at the edge only when state is IDLE and coef_addr < TAPS; otherwise silently ignored;
  - a write in the same IDLE cycle as an accepted sample takes effect for that sample.
- in_valid while in_ready=0 is ignored; the sample is not queued.
- busy = (state != IDLE).

Test Plan:
- Reset, identity coefs, TAPS=8: feed 10, -20, 127 -> outputs 10, -20, 127. Each out_valid is a single pulse following edge E0+9; in_ready is low for 9 cycles after each acceptance.
- Moving average: load all c[k]=8, feed 64 then zeros -> eight outputs of 8, then 0. Feed constant 100 -> settles to 100.
- Saturation/rounding:
  - c[0]=127: input 100 -> 127, sat_flag=1; input -100 -> -128, sat_flag=1.
  - c[0]=32: input 3 -> 2, input -3 -> -1, sat_flag=0.
- Bypass history: bypass=1, input 55 -> out_data 55 pulse following edge E0+2. Then bypass=0, load c[0]=0, c[1]=64, input 0 -> output 55.
- Coef write while busy: pulse coef_we (addr 0, data 0) during MAC -> ignored; the next sample still passes with identity gain. coef_addr=TAPS in IDLE -> ignored.
- Reset mid-MAC: assert rst at MAC cycle 3 -> no out_valid, delay line cleared. The next sample 42 -> output 42.
